// File: rtl/extencion_signo_pkg.sv
// Shared constants for the sign/zero extension block: mode encodings and default widths.
package extencion_signo_pkg;

    // Default operand widths (immediate in, extended word out).
    localparam int unsigned DEF_IN_W  = 16;
    localparam int unsigned DEF_OUT_W = 32;

    // Registered-path operation select encodings.
    localparam logic [1:0] MODE_SEXT  = 2'b00;  // sign extend
    localparam logic [1:0] MODE_ZEXT  = 2'b01;  // zero extend
    localparam logic [1:0] MODE_LUI   = 2'b10;  // immediate placed in the upper bits
    localparam logic [1:0] MODE_BROFF = 2'b11;  // sign extend, then word-align (<< 2)

endpackage

// File: rtl/ext_unit.sv
// Combinational extension mux: selects one of four ways of widening an immediate.
module ext_unit
    import extencion_signo_pkg::*;
#(
    parameter int unsigned IN_W  = DEF_IN_W,
    parameter int unsigned OUT_W = DEF_OUT_W  // must be strictly greater than IN_W
) (
    input  logic [IN_W-1:0]  instr_i,
    input  logic [1:0]       mode_i,
    output logic [OUT_W-1:0] result_o
);

    localparam int unsigned PadW = OUT_W - IN_W;

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] lui;
    logic [OUT_W-1:0] broff;

    assign sext  = {{PadW{instr_i[IN_W-1]}}, instr_i};
    assign zext  = {{PadW{1'b0}}, instr_i};
    assign lui   = {instr_i, {PadW{1'b0}}};
    // Top two sign bits fall off; the result is a word-aligned byte offset.
    assign broff = {sext[OUT_W-3:0], 2'b00};

    // Select the extension flavour requested by mode.
    always_comb begin
        result_o = sext;
        unique case (mode_i)
            MODE_SEXT:  result_o = sext;
            MODE_ZEXT:  result_o = zext;
            MODE_LUI:   result_o = lui;
            MODE_BROFF: result_o = broff;
            default:    result_o = sext;
        endcase
    end

endmodule

// File: rtl/extencion_signo.sv
// Immediate extension block: a pure combinational sign-extension output plus a
// one-cycle registered path with mode select, valid qualifier and stall.
module extencion_signo
    import extencion_signo_pkg::*;
#(
    parameter int unsigned IN_W  = DEF_IN_W,
    parameter int unsigned OUT_W = DEF_OUT_W  // must be strictly greater than IN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  instr,
    output logic [OUT_W-1:0] oinstr,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    input  logic             hold,
    output logic [OUT_W-1:0] ext_q,
    output logic             out_valid
);

    logic [OUT_W-1:0] result;
    logic [OUT_W-1:0] result_d, result_q;
    logic             valid_d, valid_q;

    // Unregistered sign extension, untouched by clock, reset or mode.
    assign oinstr = {{(OUT_W - IN_W){instr[IN_W-1]}}, instr};

    ext_unit #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_ext_unit (
        .instr_i  (instr),
        .mode_i   (mode),
        .result_o (result)
    );

    // Next state: hold freezes everything; otherwise valid follows in_valid and the
    // data register only loads on a valid operand (stale data is kept otherwise).
    always_comb begin
        result_d = result_q;
        valid_d  = valid_q;
        if (!hold) begin
            valid_d = in_valid;
            if (in_valid) begin
                result_d = result;
            end
        end
    end

    // Output registers; synchronous reset takes priority over hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign ext_q     = result_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_extencion_signo.sv
// Self-checking bench for extencion_signo: directed vector table, then random
// stimulus against an arithmetic reference model.
module tb_extencion_signo;
    import extencion_signo_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] instr;
    logic [31:0] oinstr;
    logic [1:0]  mode;
    logic        in_valid;
    logic        hold;
    logic [31:0] ext_q;
    logic        out_valid;

    int checks;
    int errors;

    extencion_signo #(
        .IN_W  (16),
        .OUT_W (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr),
        .oinstr    (oinstr),
        .mode      (mode),
        .in_valid  (in_valid),
        .hold      (hold),
        .ext_q     (ext_q),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        hold;
        logic        in_valid;
        logic [1:0]  mode;
        logic [15:0] instr;
        logic [31:0] exp_oinstr;
        logic [31:0] exp_ext;
        logic        exp_valid;
    } vec_t;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each mode computed with plain integer arithmetic.
    function automatic logic [31:0] ref_ext(input logic [15:0] i, input logic [1:0] m);
        int s;
        s = $signed(i);
        case (m)
            2'd0:    return 32'(s);
            2'd1:    return 32'(i);
            2'd2:    return 32'(i) * 32'h0001_0000;
            default: return 32'(s * 4);
        endcase
    endfunction

    vec_t vecs[16];
    logic [31:0] m_ext;
    logic        m_valid;

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        hold     = 1'b0;
        in_valid = 1'b0;
        mode     = 2'b00;
        instr    = 16'h0000;

        //           rst   hold  iv    mode   instr     oinstr        ext           v
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 2'd0, 16'hFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 2'd0, 16'h7FFF, 32'h00007FFF, 32'h00000000, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 2'd0, 16'h8000, 32'hFFFF8000, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 32'h00000000, 32'h00000000, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 2'd0, 16'h8001, 32'hFFFF8001, 32'hFFFF8001, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 2'd1, 16'h8001, 32'hFFFF8001, 32'h00008001, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 2'd2, 16'h8001, 32'hFFFF8001, 32'h80010000, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 2'd3, 16'h8001, 32'hFFFF8001, 32'hFFFE0004, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 2'd0, 16'h1234, 32'h00001234, 32'hFFFE0004, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 2'd2, 16'hABCD, 32'hFFFFABCD, 32'hFFFE0004, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 2'd2, 16'hABCD, 32'hFFFFABCD, 32'hABCD0000, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 2'd1, 16'h5555, 32'h00005555, 32'hABCD0000, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 2'd0, 16'h2222, 32'h00002222, 32'hABCD0000, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 2'd0, 16'h8000, 32'hFFFF8000, 32'h00000000, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 2'd0, 16'hC3C3, 32'hFFFFC3C3, 32'h00000000, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 2'd1, 16'h00FF, 32'h000000FF, 32'h000000FF, 1'b1};

        @(posedge clk);
        #1;

        // Directed table: oinstr checked in the same time step, registers after the edge.
        for (int k = 0; k < 16; k++) begin
            rst      = vecs[k].rst;
            hold     = vecs[k].hold;
            in_valid = vecs[k].in_valid;
            mode     = vecs[k].mode;
            instr    = vecs[k].instr;
            #1;
            check32($sformatf("vec%0d oinstr", k), oinstr, vecs[k].exp_oinstr);
            @(posedge clk);
            #1;
            check32($sformatf("vec%0d oinstr after edge", k), oinstr, vecs[k].exp_oinstr);
            check32($sformatf("vec%0d ext_q", k), ext_q, vecs[k].exp_ext);
            check1($sformatf("vec%0d out_valid", k), out_valid, vecs[k].exp_valid);
        end

        // Random phase: model carries on from the last table state.
        m_ext   = vecs[15].exp_ext;
        m_valid = vecs[15].exp_valid;
        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(0, 15) == 0);
            hold     = ($urandom_range(0, 3) == 0);
            in_valid = ($urandom_range(0, 1) == 1);
            mode     = 2'($urandom_range(0, 3));
            instr    = 16'($urandom);
            #1;
            check32("rand oinstr", oinstr, ref_ext(instr, MODE_SEXT));
            if (rst) begin
                m_ext   = 32'h0;
                m_valid = 1'b0;
            end else if (!hold) begin
                m_valid = in_valid;
                if (in_valid) m_ext = ref_ext(instr, mode);
            end
            @(posedge clk);
            #1;
            check32("rand ext_q", ext_q, m_ext);
            check1("rand out_valid", out_valid, m_valid);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/extencion_signo.md
EXTENCION_SIGNO -- requirements
Module: extencion_signo

Interface
REQ-001 Parameter IN_W, default 16, immediate input width.
REQ-002 Parameter OUT_W, default 32, extended output width; OUT_W > IN_W SHALL hold.
REQ-003 clk  input  1  single clock; all registers update on rising edge only.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 instr  input  IN_W  immediate field to extend.
REQ-006 oinstr  output  OUT_W  combinational sign-extended instr, independent of clk/rst/mode.
REQ-007 mode  input  2  registered-path operation select.
REQ-008 in_valid  input  1  registered-path operand qualifier.
REQ-009 hold  input  1  stall; freezes registered outputs when high.
REQ-010 ext_q  output  OUT_W  registered extension result.
REQ-011 out_valid  output  1  qualifies ext_q.

Function
REQ-012 oinstr SHALL equal {(OUT_W-IN_W) copies of instr[IN_W-1], instr}, purely combinational, zero cycles latency.
REQ-013 mode 00 (SEXT): result = sign extension, same as oinstr.
REQ-014 mode 01 (ZEXT): result = {(OUT_W-IN_W) zeros, instr}.
REQ-015 mode 10 (LUI): result = instr in bits [OUT_W-1:OUT_W-IN_W], zeros below.
REQ-016 mode 11 (BROFF): result = sign extension shifted left 2; the top 2 extended bits are discarded, bits [1:0] = 0.
REQ-017 Registered path latency SHALL be exactly 1 cycle: with hold=0, at a clock edge ext_q <= result(instr, mode) and out_valid <= in_valid.
REQ-018 With in_valid=0 and hold=0, ext_q SHALL keep its previous value and out_valid SHALL go to 0.
REQ-019 With hold=1, ext_q and out_valid SHALL keep their values regardless of in_valid/instr/mode.
REQ-020 rst and hold asserted on the same edge: rst SHALL win.
REQ-021 No arithmetic overflow exists; all widths are exact, no truncation other than REQ-016.

Reset
REQ-022 On a rising edge with rst=1: ext_q = 0 and out_valid = 0.
REQ-023 Reset SHALL NOT affect oinstr; oinstr follows instr during and after reset.
REQ-024 Reset asserted mid-operation SHALL discard the pending result; the first valid output after release appears 1 cycle after the first post-reset in_valid.

Structure
REQ-025 Mode encodings (SEXT, ZEXT, LUI, BROFF) and default widths SHALL be constants in the shared package extencion_signo_pkg.
REQ-026 The combinational mode mux SHALL be a sub-module ext_unit (instr, mode -> result); extencion_signo instantiates it and adds the REQ-012 path and the output registers.

Verification
REQ-027 instr=16'hFFFF -> oinstr=32'hFFFFFFFF; instr=16'h7FFF -> oinstr=32'h00007FFF, each within the same time step.
REQ-028 instr=16'h8000 -> oinstr=32'hFFFF8000; instr=16'h0000 -> oinstr=32'h00000000.
REQ-029 in_valid=1, instr=16'h8001, modes 00/01/10/11 on consecutive edges -> ext_q = FFFF8001, 00008001, 80010000, FFFE0004, each one cycle later, with out_valid=1.
REQ-030 Hold test: hold=1 while instr/mode change -> ext_q and out_valid unchanged; hold=0 -> update on the next edge.
REQ-031 Reset test: rst=1 with in_valid=1 and hold=1 -> ext_q=0 and out_valid=0 next edge; oinstr still tracks instr.
